// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 core: widths, opcode map, status bits, FSM states.
package jac_pkg;

    localparam int DataWidth     = 8;
    localparam int NumOpCodeBits = 5;
    localparam int NumStatusBits = 6;

    localparam logic [DataWidth-1:0] ResetPc = 8'h00;

    // Opcode map
    localparam logic [NumOpCodeBits-1:0] Op_NOP  = 5'h00;
    localparam logic [NumOpCodeBits-1:0] Op_ADD  = 5'h01;
    localparam logic [NumOpCodeBits-1:0] Op_SUB  = 5'h02;
    localparam logic [NumOpCodeBits-1:0] Op_AND  = 5'h03;
    localparam logic [NumOpCodeBits-1:0] Op_OR   = 5'h04;
    localparam logic [NumOpCodeBits-1:0] Op_XOR  = 5'h05;
    localparam logic [NumOpCodeBits-1:0] Op_NOT  = 5'h06;
    localparam logic [NumOpCodeBits-1:0] Op_SHL  = 5'h07;
    localparam logic [NumOpCodeBits-1:0] Op_SHR  = 5'h08;
    localparam logic [NumOpCodeBits-1:0] Op_VAL  = 5'h09;
    localparam logic [NumOpCodeBits-1:0] Op_CMP  = 5'h0A;
    localparam logic [NumOpCodeBits-1:0] Op_INC  = 5'h0B;
    localparam logic [NumOpCodeBits-1:0] Op_DEC  = 5'h0C;
    localparam logic [NumOpCodeBits-1:0] Op_GOTO = 5'h10;
    localparam logic [NumOpCodeBits-1:0] Op_IFZ  = 5'h11;
    localparam logic [NumOpCodeBits-1:0] Op_IFNZ = 5'h12;
    localparam logic [NumOpCodeBits-1:0] Op_IFEQ = 5'h13;
    localparam logic [NumOpCodeBits-1:0] Op_IFST = 5'h14;
    localparam logic [NumOpCodeBits-1:0] Op_IFGT = 5'h15;

    // Reserved ranges (inclusive)
    localparam logic [NumOpCodeBits-1:0] Op_RsvdLoFirst = 5'h0D;
    localparam logic [NumOpCodeBits-1:0] Op_RsvdLoLast  = 5'h0F;
    localparam logic [NumOpCodeBits-1:0] Op_RsvdHiFirst = 5'h16;
    localparam logic [NumOpCodeBits-1:0] Op_RsvdHiLast  = 5'h1F;

    // Status bit indices
    localparam int CarryBit       = 0;
    localparam int UnderflowBit   = 1;
    localparam int ZeroBit        = 2;
    localparam int EqualBit       = 3;
    localparam int GreaterThanBit = 4;
    localparam int SmallerThanBit = 5;

    typedef enum logic {
        St_FETCH = 1'b0,
        St_EXEC  = 1'b1
    } state_e;

endpackage

// File: rtl/jac_cond_eval.sv
// Opcode classifier and branch condition evaluator (purely combinational).
module jac_cond_eval
    import jac_pkg::*;
(
    input  logic [NumOpCodeBits-1:0] opcode,
    input  logic [NumStatusBits-1:0] status_q,
    output logic                     is_branch,
    output logic                     take,
    output logic                     is_alu_op,
    output logic                     is_reserved
);

    // Carry/Underflow never steer a branch.
    logic unused_status;
    assign unused_status = ^status_q[UnderflowBit:CarryBit];

    // Classify the opcode; anything not explicitly listed is reserved.
    always_comb begin
        is_branch   = 1'b0;
        take        = 1'b0;
        is_alu_op   = 1'b0;
        is_reserved = 1'b0;
        case (opcode)
            Op_NOP, Op_VAL: ;
            Op_ADD, Op_SUB, Op_AND, Op_OR, Op_XOR, Op_NOT,
            Op_SHL, Op_SHR, Op_CMP, Op_INC, Op_DEC: is_alu_op = 1'b1;
            Op_GOTO: begin is_branch = 1'b1; take = 1'b1;                      end
            Op_IFZ:  begin is_branch = 1'b1; take = status_q[ZeroBit];         end
            Op_IFNZ: begin is_branch = 1'b1; take = !status_q[ZeroBit];        end
            Op_IFEQ: begin is_branch = 1'b1; take = status_q[EqualBit];        end
            Op_IFST: begin is_branch = 1'b1; take = status_q[SmallerThanBit];  end
            Op_IFGT: begin is_branch = 1'b1; take = status_q[GreaterThanBit];  end
            default: is_reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/jac_flow_ctrl.sv
// Jac1-8 program-flow sequencer: fetch handshake, EXEC cycle, PC and status register.
module jac_flow_ctrl
    import jac_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     run,
    output logic                     fetch_req,
    output logic [DataWidth-1:0]     fetch_addr,
    input  logic                     fetch_ack,
    input  logic [NumOpCodeBits-1:0] instr_opcode,
    input  logic [DataWidth-1:0]     instr_param,
    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_param,
    output logic                     exec_valid,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic [NumStatusBits-1:0] status_q,
    output logic [DataWidth-1:0]     pc,
    output logic                     branch_taken,
    output logic                     illegal_op
);

    state_e state;
    logic   in_exec;
    logic   is_branch, take, is_alu_op, is_reserved;

    // Decode works on the captured opcode and the pre-EXEC status_q, so a
    // branch right after an ALU op sees that op's latched flags.
    jac_cond_eval u_cond (
        .opcode      (alu_opcode),
        .status_q    (status_q),
        .is_branch   (is_branch),
        .take        (take),
        .is_alu_op   (is_alu_op),
        .is_reserved (is_reserved)
    );

    assign in_exec      = (state == St_EXEC);
    assign fetch_req    = run && (state == St_FETCH);
    assign fetch_addr   = pc;
    assign exec_valid   = in_exec;
    assign branch_taken = in_exec && is_branch && take;
    assign illegal_op   = in_exec && is_reserved;

    // Sequencer FSM with capture, PC and status updates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= St_FETCH;
            pc         <= ResetPc;
            status_q   <= '0;
            alu_opcode <= '0;
            alu_param  <= '0;
        end else begin
            case (state)
                St_FETCH: begin
                    // fetch_req is run in FETCH, so run && ack is an acked request.
                    if (run && fetch_ack) begin
                        alu_opcode <= instr_opcode;
                        alu_param  <= instr_param;
                        state      <= St_EXEC;
                    end
                end
                St_EXEC: begin
                    if (is_branch && take) pc <= alu_param;
                    else                   pc <= pc + 8'd1;
                    if (is_alu_op) status_q <= alu_status;
                    state <= St_FETCH;
                end
                default: state <= St_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_jac_flow_ctrl.sv
// Directed bench for jac_flow_ctrl: straight line, branches, wrap, handshake, reserved op, async reset.
module tb_jac_flow_ctrl;
    import jac_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_ack;
    logic [4:0] instr_opcode;
    logic [7:0] instr_param;
    logic [4:0] alu_opcode;
    logic [7:0] alu_param;
    logic       exec_valid;
    logic [5:0] alu_status;
    logic [5:0] status_q;
    logic [7:0] pc;
    logic       branch_taken;
    logic       illegal_op;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] obs_addr;
    logic       obs_fexec, obs_exec, obs_taken, obs_ill;
    logic [4:0] obs_aop;

    jac_flow_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .instr_opcode (instr_opcode),
        .instr_param  (instr_param),
        .alu_opcode   (alu_opcode),
        .alu_param    (alu_param),
        .exec_valid   (exec_valid),
        .alu_status   (alu_status),
        .status_q     (status_q),
        .pc           (pc),
        .branch_taken (branch_taken),
        .illegal_op   (illegal_op)
    );

    always #5 clock = ~clock;

    // One instruction: entered just after a negedge with the DUT in FETCH,
    // leaves just after the negedge of the following FETCH cycle.
    task automatic do_fetch(input logic [4:0] op, input logic [7:0] prm, input logic [5:0] st);
        instr_opcode = op; instr_param = prm; alu_status = st; fetch_ack = 1'b1;
        #1;
        obs_addr = fetch_addr; obs_fexec = exec_valid;
        @(negedge clock);
        fetch_ack = 1'b0; instr_opcode = 5'h00; instr_param = 8'h00;
        #1;
        obs_exec = exec_valid; obs_taken = branch_taken; obs_ill = illegal_op; obs_aop = alu_opcode;
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; fetch_ack = 1'b0;
        instr_opcode = 5'h00; instr_param = 8'h00; alu_status = 6'h00;
        @(negedge clock); #1;
        n_total++; if (pc !== 8'h00) $display("FAIL rst_pc got %h exp 00", pc); else n_pass++;
        n_total++; if (status_q !== 6'h00) $display("FAIL rst_status got %h exp 00", status_q); else n_pass++;
        n_total++; if (alu_opcode !== 5'h00 || alu_param !== 8'h00) $display("FAIL rst_capture got %h/%h exp 00/00", alu_opcode, alu_param); else n_pass++;
        n_total++; if ({exec_valid, branch_taken, illegal_op} !== 3'b000) $display("FAIL rst_pulses got %b exp 000", {exec_valid, branch_taken, illegal_op}); else n_pass++;
        n_total++; if (fetch_req !== 1'b0) $display("FAIL rst_req_run0 got %b exp 0", fetch_req); else n_pass++;
        run = 1'b1; #1;
        n_total++; if (fetch_req !== 1'b1) $display("FAIL rst_req_run1 got %b exp 1", fetch_req); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_straight_line();
        do_fetch(Op_ADD, 8'h05, 6'b00_0001);
        n_total++; if (obs_addr !== 8'h00) $display("FAIL add_addr got %h exp 00", obs_addr); else n_pass++;
        n_total++; if (obs_fexec !== 1'b0 || obs_exec !== 1'b1) $display("FAIL add_exec got %b%b exp 01", obs_fexec, obs_exec); else n_pass++;
        n_total++; if (obs_aop !== Op_ADD) $display("FAIL add_aop got %h exp %h", obs_aop, Op_ADD); else n_pass++;
        n_total++; if (status_q !== 6'b00_0001 || pc !== 8'h01) $display("FAIL add_after got st %h pc %h exp 01 01", status_q, pc); else n_pass++;
        n_total++; if (exec_valid !== 1'b0) $display("FAIL add_fetch_exec got %b exp 0", exec_valid); else n_pass++;
        do_fetch(Op_SUB, 8'h01, 6'b00_0110);
        n_total++; if (obs_addr !== 8'h01 || obs_exec !== 1'b1) $display("FAIL sub_addr got %h/%b exp 01/1", obs_addr, obs_exec); else n_pass++;
        n_total++; if (status_q !== 6'b00_0110) $display("FAIL sub_status got %h exp 06", status_q); else n_pass++;
        do_fetch(Op_NOP, 8'h00, 6'b11_1111);
        n_total++; if (obs_addr !== 8'h02 || obs_exec !== 1'b1) $display("FAIL nop_addr got %h/%b exp 02/1", obs_addr, obs_exec); else n_pass++;
        n_total++; if (status_q !== 6'b00_0110 || pc !== 8'h03) $display("FAIL nop_after got st %h pc %h exp 06 03", status_q, pc); else n_pass++;
    endtask

    task automatic test_cond_branch();
        do_fetch(Op_SUB, 8'h00, 6'b00_0100);
        do_fetch(Op_IFZ, 8'h40, 6'b00_0000);
        n_total++; if (obs_addr !== 8'h04 || obs_taken !== 1'b1) $display("FAIL ifz_taken got %h/%b exp 04/1", obs_addr, obs_taken); else n_pass++;
        n_total++; if (fetch_addr !== 8'h40) $display("FAIL ifz_target got %h exp 40", fetch_addr); else n_pass++;
        n_total++; if (status_q !== 6'b00_0100) $display("FAIL ifz_status got %h exp 04", status_q); else n_pass++;
        do_fetch(Op_SUB, 8'h00, 6'b00_0100);
        do_fetch(Op_IFNZ, 8'h50, 6'b00_0000);
        n_total++; if (obs_taken !== 1'b0 || obs_exec !== 1'b1) $display("FAIL ifnz_pulse got %b/%b exp 0/1", obs_taken, obs_exec); else n_pass++;
        n_total++; if (fetch_addr !== 8'h42) $display("FAIL ifnz_next got %h exp 42", fetch_addr); else n_pass++;
    endtask

    task automatic test_compare_chain();
        do_fetch(Op_CMP, 8'h00, 6'b01_0000);
        n_total++; if (status_q !== 6'b01_0000) $display("FAIL cmp_status got %h exp 10", status_q); else n_pass++;
        do_fetch(Op_IFGT, 8'h10, 6'b10_0000);
        n_total++; if (obs_taken !== 1'b1 || fetch_addr !== 8'h10) $display("FAIL ifgt got %b/%h exp 1/10", obs_taken, fetch_addr); else n_pass++;
        do_fetch(Op_IFST, 8'h20, 6'b10_0000);
        n_total++; if (obs_taken !== 1'b0 || fetch_addr !== 8'h11) $display("FAIL ifst got %b/%h exp 0/11", obs_taken, fetch_addr); else n_pass++;
        n_total++; if (status_q !== 6'b01_0000) $display("FAIL chain_status got %h exp 10", status_q); else n_pass++;
    endtask

    task automatic test_wrap_goto();
        do_fetch(Op_GOTO, 8'hFF, 6'b00_0000);
        n_total++; if (obs_taken !== 1'b1 || pc !== 8'hFF) $display("FAIL goto got %b/%h exp 1/ff", obs_taken, pc); else n_pass++;
        do_fetch(Op_NOP, 8'h00, 6'b00_0000);
        n_total++; if (obs_addr !== 8'hFF || obs_taken !== 1'b0) $display("FAIL nop_ff got %h/%b exp ff/0", obs_addr, obs_taken); else n_pass++;
        n_total++; if (fetch_addr !== 8'h00) $display("FAIL wrap got %h exp 00", fetch_addr); else n_pass++;
    endtask

    task automatic test_handshake();
        run = 1'b1; fetch_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            n_total++; if (fetch_req !== 1'b1 || fetch_addr !== 8'h00) $display("FAIL wait_req got %b/%h exp 1/00", fetch_req, fetch_addr); else n_pass++;
            n_total++; if (exec_valid !== 1'b0) $display("FAIL wait_exec got %b exp 0", exec_valid); else n_pass++;
        end
        run = 1'b0; #1;
        n_total++; if (fetch_req !== 1'b0) $display("FAIL drop_req got %b exp 0", fetch_req); else n_pass++;
        fetch_ack = 1'b1; instr_opcode = Op_GOTO; instr_param = 8'h77;
        @(negedge clock); #1;
        n_total++; if (exec_valid !== 1'b0 || pc !== 8'h00) $display("FAIL stray_ack got %b/%h exp 0/00", exec_valid, pc); else n_pass++;
        n_total++; if (alu_opcode !== Op_NOP || alu_param !== 8'h00) $display("FAIL stray_cap got %h/%h exp 00/00", alu_opcode, alu_param); else n_pass++;
        fetch_ack = 1'b0; instr_opcode = 5'h00; instr_param = 8'h00; run = 1'b1;
    endtask

    task automatic test_reserved();
        do_fetch(5'b1_1000, 8'h33, 6'b11_1111);
        n_total++; if (obs_ill !== 1'b1 || obs_taken !== 1'b0) $display("FAIL rsvd_pulse got %b/%b exp 1/0", obs_ill, obs_taken); else n_pass++;
        n_total++; if (pc !== 8'h01 || status_q !== 6'b01_0000) $display("FAIL rsvd_after got pc %h st %h exp 01 10", pc, status_q); else n_pass++;
        n_total++; if (illegal_op !== 1'b0) $display("FAIL rsvd_clear got %b exp 0", illegal_op); else n_pass++;
        do_fetch(Op_VAL, 8'h09, 6'b11_1111);
        n_total++; if (obs_ill !== 1'b0 || pc !== 8'h02 || status_q !== 6'b01_0000) $display("FAIL val got %b/%h/%h exp 0/02/10", obs_ill, pc, status_q); else n_pass++;
    endtask

    task automatic test_async_reset();
        instr_opcode = Op_ADD; instr_param = 8'h11; alu_status = 6'b11_1111; fetch_ack = 1'b1;
        @(negedge clock);
        fetch_ack = 1'b0; #1;
        n_total++; if (exec_valid !== 1'b1) $display("FAIL pre_rst_exec got %b exp 1", exec_valid); else n_pass++;
        #1 reset_n = 1'b0; #1;
        n_total++; if (pc !== 8'h00 || status_q !== 6'h00) $display("FAIL async_rst got pc %h st %h exp 00 00", pc, status_q); else n_pass++;
        n_total++; if (exec_valid !== 1'b0 || alu_opcode !== 5'h00) $display("FAIL async_rst_exec got %b/%h exp 0/00", exec_valid, alu_opcode); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1; #1;
        n_total++; if (fetch_req !== 1'b1 || fetch_addr !== 8'h00) $display("FAIL post_rst_req got %b/%h exp 1/00", fetch_req, fetch_addr); else n_pass++;
        do_fetch(Op_INC, 8'h00, 6'b00_1000);
        n_total++; if (obs_exec !== 1'b1 || pc !== 8'h01 || status_q !== 6'b00_1000) $display("FAIL post_rst_fetch got %b/%h/%h exp 1/01/08", obs_exec, pc, status_q); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_cond_branch();
        test_compare_chain();
        test_wrap_goto();
        test_handshake();
        test_reserved();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
